// File: rtl/openmips_pkg.sv
// openmips_pkg
//    Shared definitions for the five-stage core control path: stall vector
//    encodings (bit 0 = PC ... bit 5 = WB), MEM-stage exception codes and
//    the divide sequencer state type.
package openmips_pkg;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;  // PC, IF/ID, ID/EX
   localparam logic [5:0] STALL_EX   = 6'b001111;  // PC .. EX/MEM

   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_INV     = 32'h0000_000a;
   localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//    Central pipeline control: merges ID/EX stall requests, sequences
//    multi-cycle divides and converts MEM-stage exceptions into a one-cycle
//    flush with a redirect PC.
//
//    Ports
//       clk, rst      : clock, synchronous active-high reset
//       stallreq_id   : load-use bubble request from ID
//       stallreq_ex   : extra-cycle request from EX (madd/msub)
//       div_start     : divide present in EX (held while it sits there)
//       except_type   : MEM exception code, 0 = none
//       cp0_epc       : EPC, redirect target for eret
//       stall[5:0]    : per-register hold enables (0 = PC ... 5 = WB)
//       flush         : clear all pipeline registers this cycle
//       new_pc        : redirect target, zero unless flush
//       div_ready     : one-cycle strobe, divide result valid in EX
//       stall_cycles  : saturating count of cycles with stall[0] set
module pipeline_ctrl
   import openmips_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 34,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        div_start,
   input  logic [31:0] except_type,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        div_ready,
   output logic [15:0] stall_cycles
);

   localparam int unsigned     CW       = $clog2(DIV_CYCLES);
   // The start cycle and the DONE-entry cycle are not counted, hence -2.
   localparam logic [CW-1:0]   CNT_LOAD = CW'(DIV_CYCLES - 2);

   div_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   stall_cnt_q, stall_cnt_d;
   logic          ex_req;

   // Exception decode; reset masks the flush entirely.
   always_comb begin
      flush  = ~rst & (|except_type);
      new_pc = '0;
      if (flush) begin
         new_pc = (except_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;
      end
   end

   // Stall priority mux: reset, flush, EX-class, ID, none.
   always_comb begin
      ex_req = stallreq_ex | (state_q == BUSY) | ((state_q == IDLE) & div_start);
      stall  = STALL_NONE;
      if (rst || flush) begin
         stall = STALL_NONE;
      end else if (ex_req) begin
         stall = STALL_EX;
      end else if (stallreq_id) begin
         stall = STALL_ID;
      end
   end

   // Divide sequencer next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (div_start) begin
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            DONE:    state_d = IDLE;  // div_start here is the finishing divide
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Strobe comes from the state register; a same-cycle flush or reset
   // cancels it so a squashed divide never reports a result.
   assign div_ready = (state_q == DONE) & ~flush & ~rst;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall[0] && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst, stallreq_id, stallreq_ex, div_start;
   logic [31:0] except_type, cp0_epc;
   logic [5:0]  stall;
   logic        flush, div_ready;
   logic [31:0] new_pc;
   logic [15:0] stall_cycles;

   pipeline_ctrl #(.DIV_CYCLES(D), .EXC_VECTOR(32'h0000_0020)) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .div_start(div_start), .except_type(except_type), .cp0_epc(cp0_epc),
      .stall(stall), .flush(flush), .new_pc(new_pc), .div_ready(div_ready),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: m_t = cycles since divide start (-1 = no divide).
   int  m_t = -1;
   int  m_cnt = 0;
   bit  mvalid = 0;

   // Outputs sampled mid-cycle.
   logic [5:0]  s_stall;
   logic        s_flush, s_ready;
   logic [31:0] s_pc;
   logic [15:0] s_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic id, input logic ex, input logic ds,
                      input logic [31:0] et, input logic [31:0] epc);
      logic        e_flush, e_ready, div_stall;
      logic [5:0]  e_stall;
      logic [31:0] e_pc;
      rst = r; stallreq_id = id; stallreq_ex = ex; div_start = ds;
      except_type = et; cp0_epc = epc;
      @(negedge clk);
      s_stall = stall; s_flush = flush; s_ready = div_ready; s_pc = new_pc; s_cnt = stall_cycles;
      e_flush   = !r && (et != 0);
      e_pc      = e_flush ? ((et == 32'he) ? epc : 32'h20) : 32'h0;
      div_stall = (m_t < 0) ? ds : (m_t < D);
      e_ready   = !r && !e_flush && (m_t == D);
      if (r || e_flush)          e_stall = 6'b000000;
      else if (ex || div_stall)  e_stall = 6'b001111;
      else if (id)               e_stall = 6'b000111;
      else                       e_stall = 6'b000000;
      if (mvalid) begin
         chk("model_stall", 32'(s_stall), 32'(e_stall));
         chk("model_flush", 32'(s_flush), 32'(e_flush));
         chk("model_new_pc", s_pc, e_pc);
         chk("model_div_ready", 32'(s_ready), 32'(e_ready));
         chk("model_stall_cycles", 32'(s_cnt), m_cnt);
      end
      if (r) begin
         m_t = -1; m_cnt = 0; mvalid = 1;
      end else begin
         if (e_stall[0] && m_cnt < 65535) m_cnt++;
         if (e_flush)           m_t = -1;
         else if (m_t < 0)      m_t = ds ? 1 : -1;
         else if (m_t == D)     m_t = -1;
         else                   m_t++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic rst_cyc();
      cyc(1, 0, 0, 0, 32'h0, 32'h0);
   endtask

   typedef struct {
      logic        r, id, ex, ds;
      logic [31:0] et, epc;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[12];

   initial begin
      //          r    id   ex   ds   et          epc           stall      fl   new_pc
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,      32'h0,        6'b000000, 1'b0,32'h0};
      tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,      32'h0,        6'b000111, 1'b0,32'h0};
      tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,      32'h0,        6'b001111, 1'b0,32'h0};
      tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,      32'h0,        6'b001111, 1'b0,32'h0};
      tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,32'h0,      32'h0,        6'b001111, 1'b0,32'h0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,32'h1,      32'h5555,     6'b000000, 1'b1,32'h20};
      tbl[6]  = '{1'b0,1'b1,1'b1,1'b1,32'h8,      32'h0,        6'b000000, 1'b1,32'h20};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,32'he,      32'h1234,     6'b000000, 1'b1,32'h1234};
      tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,32'he,      32'h1234,     6'b000000, 1'b0,32'h0};
      tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,32'h0,      32'h0,        6'b000000, 1'b0,32'h0};
      tbl[10] = '{1'b0,1'b1,1'b0,1'b0,32'hc,      32'hdead_beef,6'b000000, 1'b1,32'h20};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b0,32'hd,      32'h0,        6'b000000, 1'b1,32'h20};

      rst = 1; stallreq_id = 0; stallreq_ex = 0; div_start = 0; except_type = '0; cp0_epc = '0;
      @(posedge clk); #1;

      // Reset with every request high.
      cyc(1, 1, 1, 1, 32'h8, 32'h1234);
      chk("rst_stall", 32'(s_stall), 32'h0);
      chk("rst_flush", 32'(s_flush), 32'h0);
      cyc(1, 1, 1, 1, 32'h8, 32'h1234);
      chk("rst_stall2", 32'(s_stall), 32'h0);
      chk("rst_ready", 32'(s_ready), 32'h0);
      chk("rst_cnt", 32'(s_cnt), 32'h0);

      // Single-cycle vectors, each from a freshly reset IDLE state.
      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].id, tbl[i].ex, tbl[i].ds, tbl[i].et, tbl[i].epc);
         chk($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(tbl[i].st));
         chk($sformatf("vec%0d_flush", i), 32'(s_flush), 32'(tbl[i].fl));
         chk($sformatf("vec%0d_new_pc", i), s_pc, tbl[i].pc);
         rst_cyc();
      end

      // Load-use pulse.
      cyc(0, 1, 0, 0, 32'h0, 32'h0);
      chk("loaduse_stall", 32'(s_stall), 32'h07);
      idle_cyc();
      chk("loaduse_after", 32'(s_stall), 32'h0);
      chk("loaduse_cnt", 32'(s_cnt), 32'd1);
      rst_cyc();

      // Divide held T0..T4, with an ID request inside BUSY.
      for (int t = 0; t <= D; t++) begin
         cyc(0, (t == 2), 0, 1, 32'h0, 32'h0);
         if (t < D) begin
            chk($sformatf("div_T%0d_stall", t), 32'(s_stall), 32'h0f);
            chk($sformatf("div_T%0d_ready", t), 32'(s_ready), 32'h0);
         end else begin
            chk("div_T4_stall", 32'(s_stall), 32'h0);
            chk("div_T4_ready", 32'(s_ready), 32'h1);
         end
      end
      idle_cyc();
      chk("div_T5_ready", 32'(s_ready), 32'h0);
      chk("div_T5_stall", 32'(s_stall), 32'h0);
      chk("div_cnt", 32'(s_cnt), 32'd4);
      rst_cyc();

      // Flush at T2 of a divide.
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 32'h8, 32'h0);
      chk("flushdiv_flush", 32'(s_flush), 32'h1);
      chk("flushdiv_pc", s_pc, 32'h20);
      chk("flushdiv_stall", 32'(s_stall), 32'h0);
      for (int t = 0; t < D + 2; t++) begin
         idle_cyc();
         chk($sformatf("flushdiv_idle%0d_stall", t), 32'(s_stall), 32'h0);
         chk($sformatf("flushdiv_idle%0d_ready", t), 32'(s_ready), 32'h0);
      end
      rst_cyc();

      // Exception together with div_start in IDLE: stays IDLE.
      cyc(0, 0, 0, 1, 32'h1, 32'h0);
      chk("excstart_stall", 32'(s_stall), 32'h0);
      idle_cyc();
      chk("excstart_next_stall", 32'(s_stall), 32'h0);
      rst_cyc();

      // stallreq_ex while in DONE.
      for (int t = 0; t < D; t++) cyc(0, 0, 0, 1, 32'h0, 32'h0);
      cyc(0, 0, 1, 1, 32'h0, 32'h0);
      chk("done_ex_stall", 32'(s_stall), 32'h0f);
      chk("done_ex_ready", 32'(s_ready), 32'h1);
      idle_cyc();
      chk("done_ex_ready_next", 32'(s_ready), 32'h0);
      rst_cyc();

      // Reset during BUSY.
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      cyc(1, 0, 0, 1, 32'h0, 32'h0);
      chk("rstbusy_stall", 32'(s_stall), 32'h0);
      idle_cyc();
      chk("rstbusy_next_stall", 32'(s_stall), 32'h0);
      chk("rstbusy_next_ready", 32'(s_ready), 32'h0);
      chk("rstbusy_next_cnt", 32'(s_cnt), 32'h0);

      // Randomised traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] et;
         et = 32'h0;
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 5))
               0: et = 32'h1;
               1: et = 32'h8;
               2: et = 32'ha;
               3: et = 32'hc;
               4: et = 32'hd;
               default: et = 32'he;
            endcase
         end
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 3), et, $urandom);
      end

      // Saturation of the stall counter.
      rst_cyc();
      for (int n = 0; n < 70000; n++) cyc(0, 0, 1, 0, 32'h0, 32'h0);
      chk("sat_cnt", 32'(s_cnt), 32'hffff);
      cyc(0, 0, 1, 0, 32'h0, 32'h0);
      idle_cyc();
      chk("sat_hold", 32'(s_cnt), 32'hffff);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
